// File: rtl/sc_istream_packer.sv
// Instruction-byte stream packer: collects little-endian fetch beats into a
// byte window for the decoder and retires decoder-consumed bytes.
module sc_istream_packer #(
  parameter int unsigned STREAM_BYTES    = 34,
  parameter int unsigned IN_BYTES        = 4,
  parameter bit          DISCARD_REMNANT = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [IN_BYTES*8-1:0]     in_data,
  input  logic [2:0]                in_bytes,
  input  logic                      in_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [STREAM_BYTES*8-1:0] out_data,
  output logic [5:0]                out_len,
  input  logic [5:0]                dec_used,
  output logic                      err
);

  localparam int unsigned WIN_W    = STREAM_BYTES * 8;
  localparam int unsigned BEAT_W   = IN_BYTES * 8;
  localparam logic [5:0]  FILL_MAX = 6'(STREAM_BYTES - IN_BYTES);
  localparam logic [2:0]  BEAT_MAX = 3'(IN_BYTES);

  typedef enum logic {S_FILL, S_PRESENT} state_e;

  state_e             state_q, state_d;
  logic [5:0]         cnt_q, cnt_d;
  logic [WIN_W-1:0]   win_q, win_d;
  logic               pend_q, pend_d;
  logic               err_q, err_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;

  logic [2:0]         nb;
  logic [BEAT_W-1:0]  beat_m;
  logic [5:0]         cnt_acc;
  logic               illegal;
  logic [5:0]         use_amt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_FILL;
      cnt_q       <= 6'd0;
      win_q       <= '0;
      pend_q      <= 1'b0;
      err_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      win_q       <= win_d;
      pend_q      <= pend_d;
      err_q       <= err_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Bytes at index >= cnt are always zero, so appends can simply OR in.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    win_d   = win_q;
    pend_d  = pend_q;
    err_d   = 1'b0;

    nb = (in_bytes > BEAT_MAX) ? BEAT_MAX : in_bytes;
    beat_m = '0;
    for (int unsigned i = 0; i < IN_BYTES; i++) begin
      if (3'(i) < nb) beat_m[i*8 +: 8] = in_data[i*8 +: 8];
    end
    cnt_acc = cnt_q + 6'(nb);
    illegal = (dec_used == 6'd0) || (dec_used > cnt_q);
    use_amt = illegal ? cnt_q : dec_used;

    case (state_q)
      S_FILL: begin
        if (in_valid && in_ready_q) begin
          win_d  = win_q | (WIN_W'(beat_m) << {cnt_q, 3'b000});
          cnt_d  = cnt_acc;
          pend_d = in_last;
          if ((cnt_acc > FILL_MAX) || (in_last && (cnt_acc != 6'd0))) state_d = S_PRESENT;
        end
      end
      S_PRESENT: begin
        if (out_ready) begin
          err_d = illegal;
          if (DISCARD_REMNANT) begin
            win_d   = '0;
            cnt_d   = 6'd0;
            pend_d  = 1'b0;
            state_d = S_FILL;
          end else begin
            win_d = win_q >> {use_amt, 3'b000};
            cnt_d = cnt_q - use_amt;
            // A pending last chunk drains remnants without waiting for input.
            if ((pend_q && (cnt_d != 6'd0)) || (cnt_d > FILL_MAX)) state_d = S_PRESENT;
            else state_d = S_FILL;
            if (cnt_d == 6'd0) pend_d = 1'b0;
          end
        end
      end
      default: state_d = S_FILL;
    endcase

    in_ready_d  = (state_d == S_FILL) && (cnt_d <= FILL_MAX);
    out_valid_d = (state_d == S_PRESENT);
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = win_q;
  assign out_len   = cnt_q;
  assign err       = err_q;

endmodule

// File: tb/tb_sc_istream_packer.sv
// Bench for sc_istream_packer: one instance per remnant policy, checked
// against a byte-queue reference model under directed and random stimulus.
module tb_sc_istream_packer;

  localparam int S    = 34;
  localparam int FMAX = 30;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        sel;
  logic        in_valid, in_last, out_ready;
  logic [31:0] in_data;
  logic [2:0]  in_bytes;
  logic [5:0]  dec_used;

  logic        a_in_ready, a_out_valid, a_err;
  logic [271:0] a_out_data;
  logic [5:0]  a_out_len;
  logic        b_in_ready, b_out_valid, b_err;
  logic [271:0] b_out_data;
  logic [5:0]  b_out_len;

  logic        o_in_ready, o_out_valid, o_err;
  logic [271:0] o_out_data;
  logic [5:0]  o_out_len;

  sc_istream_packer #(.STREAM_BYTES(34), .IN_BYTES(4), .DISCARD_REMNANT(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid & ~sel), .in_ready(a_in_ready),
    .in_data(in_data), .in_bytes(in_bytes), .in_last(in_last),
    .out_valid(a_out_valid), .out_ready(out_ready & ~sel),
    .out_data(a_out_data), .out_len(a_out_len),
    .dec_used(dec_used), .err(a_err)
  );

  sc_istream_packer #(.STREAM_BYTES(34), .IN_BYTES(4), .DISCARD_REMNANT(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid & sel), .in_ready(b_in_ready),
    .in_data(in_data), .in_bytes(in_bytes), .in_last(in_last),
    .out_valid(b_out_valid), .out_ready(out_ready & sel),
    .out_data(b_out_data), .out_len(b_out_len),
    .dec_used(dec_used), .err(b_err)
  );

  assign o_in_ready  = sel ? b_in_ready  : a_in_ready;
  assign o_out_valid = sel ? b_out_valid : a_out_valid;
  assign o_err       = sel ? b_err       : a_err;
  assign o_out_data  = sel ? b_out_data  : a_out_data;
  assign o_out_len   = sel ? b_out_len   : a_out_len;

  // Reference model: the window is a plain byte queue.
  byte unsigned m_q[$];
  bit m_pres, m_pend, m_err;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [271:0] got, input logic [271:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [271:0] m_data();
    logic [271:0] r = '0;
    for (int i = 0; i < m_q.size(); i++) r[i*8 +: 8] = m_q[i];
    return r;
  endfunction

  task automatic check_all(input string tag);
    chk({tag, "_valid"}, 272'(o_out_valid), 272'(m_pres));
    chk({tag, "_len"},   272'(o_out_len),   272'(m_q.size()));
    chk({tag, "_data"},  o_out_data,        m_data());
    chk({tag, "_ready"}, 272'(o_in_ready),  272'(!m_pres && m_q.size() <= FMAX));
    chk({tag, "_err"},   272'(o_err),       272'(m_err));
  endtask

  // Advance model and DUT by one clock using the currently driven inputs.
  task automatic tick(input string tag);
    int u, nb;
    m_err = 1'b0;
    if (!m_pres) begin
      if (in_valid && m_q.size() <= FMAX) begin
        nb = (in_bytes > 3'd4) ? 4 : int'(in_bytes);
        for (int k = 0; k < nb; k++) m_q.push_back(in_data[k*8 +: 8]);
        m_pend = in_last;
        if (m_q.size() > FMAX || (in_last && m_q.size() > 0)) m_pres = 1'b1;
      end
    end else if (out_ready) begin
      u = int'(dec_used);
      if (u == 0 || u > m_q.size()) begin
        m_err = 1'b1;
        u = m_q.size();
      end
      if (!sel) begin
        m_q.delete();
        m_pend = 1'b0;
        m_pres = 1'b0;
      end else begin
        repeat (u) void'(m_q.pop_front());
        m_pres = (m_pend && m_q.size() > 0) || (m_q.size() > FMAX);
        if (m_q.size() == 0) m_pend = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic beat(input logic [31:0] d, input logic [2:0] n, input logic last, input string tag);
    in_valid = 1'b1; in_data = d; in_bytes = n; in_last = last;
    tick(tag);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic consume(input int u, input string tag);
    out_ready = 1'b1; dec_used = 6'(u);
    tick(tag);
    out_ready = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    in_data = '0; in_bytes = '0; dec_used = '0;
    #1;
    chk({tag, "_rst_valid"}, 272'(o_out_valid), 272'(0));
    chk({tag, "_rst_len"},   272'(o_out_len),   272'(0));
    chk({tag, "_rst_data"},  o_out_data,        272'(0));
    chk({tag, "_rst_err"},   272'(o_err),       272'(0));
    m_q.delete(); m_pres = 1'b0; m_pend = 1'b0; m_err = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk({tag, "_rst_ready"}, 272'(o_in_ready), 272'(1));
  endtask

  task automatic fill32(input string tag);
    for (int b = 0; b < 8; b++)
      beat({8'(4*b+3), 8'(4*b+2), 8'(4*b+1), 8'(4*b)}, 3'd4, 1'b0, tag);
  endtask

  logic [271:0] e;

  initial begin
    sel = 1'b0;
    do_reset("init");

    // Discard mode: full fill
    fill32("fill");
    e = '0;
    for (int i = 0; i < 32; i++) e[i*8 +: 8] = 8'(i);
    chk("fill_len_k",  272'(o_out_len), 272'(32));
    chk("fill_data_k", o_out_data, e);
    consume(32, "fill_use");

    // Partial beat with last; upper in_data bytes must be ignored
    beat(32'hA3A2A1A0, 3'd4, 1'b0, "part");
    beat(32'hEEEEB1B0, 3'd2, 1'b1, "part");
    chk("part_data_k", o_out_data, 272'h B1B0_A3A2_A1A0);
    chk("part_len_k",  272'(o_out_len), 272'(6));
    consume(6, "part_use");
    chk("part_err_k", 272'(o_err), 272'(0));

    // Illegal consume: too many, then zero
    beat(32'hA3A2A1A0, 3'd4, 1'b0, "ill");
    beat(32'h0000B1B0, 3'd2, 1'b1, "ill");
    consume(9, "ill9");
    chk("ill9_err_k", 272'(o_err), 272'(1));
    tick("ill9_after");
    beat(32'h11223344, 3'd7, 1'b0, "ill0");
    beat(32'h0, 3'd0, 1'b1, "ill0");
    consume(0, "ill0");
    chk("ill0_err_k", 272'(o_err), 272'(1));
    beat(32'h0, 3'd0, 1'b1, "bare_last");

    // Back-pressure then reset mid-PRESENT
    beat(32'hDDCCBBAA, 3'd3, 1'b1, "bp");
    out_ready = 1'b0;
    repeat (5) tick("bp_hold");
    chk("bp_data_k", o_out_data, 272'h CC_BBAA);
    do_reset("midrst");

    // Remnant mode
    sel = 1'b1;
    do_reset("rem");
    fill32("rem_fill");
    consume(10, "rem_use");
    e = '0;
    for (int i = 0; i < 22; i++) e[i*8 +: 8] = 8'(i + 10);
    chk("rem_data_k",  o_out_data, e);
    chk("rem_len_k",   272'(o_out_len), 272'(22));
    chk("rem_ready_k", 272'(o_in_ready), 272'(1));
    beat(32'h03020100, 3'd4, 1'b1, "rem_flush");
    consume(26, "rem_flush_use");

    // Remnant above the fill threshold keeps presenting
    fill32("rem_hi");
    consume(1, "rem_hi_use");
    chk("rem_hi_valid_k", 272'(o_out_valid), 272'(1));
    consume(31, "rem_hi_done");

    // Last drain: 12 bytes with last, consumed 4 at a time
    beat(32'h03020100, 3'd4, 1'b0, "drain");
    beat(32'h07060504, 3'd4, 1'b0, "drain");
    beat(32'h0B0A0908, 3'd4, 1'b1, "drain");
    chk("drain_len12_k", 272'(o_out_len), 272'(12));
    consume(4, "drain1");
    chk("drain_len8_k", 272'(o_out_len), 272'(8));
    consume(4, "drain2");
    chk("drain_len4_k", 272'(o_out_len), 272'(4));
    consume(4, "drain3");
    chk("drain_fill_k", 272'(o_out_valid), 272'(0));

    // Illegal consume in remnant mode drops the whole window
    beat(32'hA3A2A1A0, 3'd4, 1'b0, "rill");
    beat(32'h0000B1B0, 3'd2, 1'b1, "rill");
    consume(9, "rill9");
    chk("rill9_len_k", 272'(o_out_len), 272'(0));

    // Random traffic in both modes
    for (int m = 0; m < 2; m++) begin
      sel = m[0];
      do_reset("rnd");
      for (int c = 0; c < 1500; c++) begin
        if ($urandom_range(0, 299) == 0) do_reset("rnd_mid");
        in_valid  = 1'($urandom_range(0, 1));
        in_data   = $urandom;
        in_bytes  = 3'($urandom_range(0, 7));
        in_last   = ($urandom_range(0, 7) == 0);
        out_ready = ($urandom_range(0, 2) != 0);
        if ($urandom_range(0, 9) == 0 || m_q.size() == 0)
          dec_used = 6'($urandom_range(0, 40));
        else
          dec_used = 6'($urandom_range(1, m_q.size()));
        tick("rnd");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sc_istream_packer.md
# sc_istream_packer

Upstream feeder of the instruction decoder. Accepts instruction bytes from the fetch/simulation interface in 32-bit little-endian beats, packs them into a 272-bit (34-byte) stream window, and presents the window to the decoder with a valid/ready handshake. Handles decoder-reported consumption either by discarding the remnant or by shifting it down to the front of the window, selected by parameter.

## Interface
- STREAM_BYTES, 34: window capacity in bytes; must equal decoder stream capacity.
- IN_BYTES, 4: input beat width in bytes.
- DISCARD_REMNANT, 1: 1 = unconsumed bytes dropped after each decode; 0 = remnant shifted to byte 0 and kept.
- clk  in  1  sole clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  packer can accept a beat.
- in_data  in  32  beat bytes, byte 0 at bits [7:0].
- in_bytes  in  3  number of valid low-order bytes, 0..4.
- in_last  in  1  end of chunk: present window even if not full.
- out_valid  out  1  window valid for decoder.
- out_ready  in  1  decoder takes window this cycle.
- out_data  out  272  window, byte 0 at bits [7:0]; bytes at index >= out_len read 0.
- out_len  out  6  valid bytes in window, 0..34.
- dec_used  in  6  bytes consumed by decoder, sampled on out handshake.
- err  out  1  one-cycle pulse on illegal dec_used.

## Operation
- State: FILL / PRESENT; byte counter cnt (0..34); byte buffer buf[0..33]; flag pend_last.
- in_ready = (state == FILL) && (cnt <= STREAM_BYTES - IN_BYTES).
- FILL, in_valid && in_ready: buf[cnt + i] <= in_data byte i for i < in_bytes; cnt <= cnt + in_bytes.
  - in_bytes > 4 treated as 4.
  - in_bytes = 0 accepted, no append (bare last marker).
  - Next state PRESENT if new cnt > STREAM_BYTES - IN_BYTES, or (in_last && new cnt > 0). pend_last <= in_last.
  - in_last with new cnt = 0: stay FILL, nothing presented.
- PRESENT: out_valid = 1, out_len = cnt, out_data = buf. No input accepted.
- PRESENT, out_valid && out_ready: u = dec_used.
  - u = 0 or u > cnt: err pulses next cycle; u treated as cnt.
  - DISCARD_REMNANT = 1: buf cleared, cnt <= 0, pend_last <= 0, state FILL.
  - DISCARD_REMNANT = 0: buf shifted down by u bytes, vacated top bytes zeroed, cnt <= cnt - u.
    - pend_last && new cnt > 0: stay PRESENT (drain remnant without waiting for input).
    - new cnt > STREAM_BYTES - IN_BYTES: stay PRESENT.
    - otherwise FILL; pend_last cleared when new cnt = 0.
- Arithmetic: cnt, u unsigned 6-bit; shift amount is byte-granular (u*8 bits).

## Timing
- Reset (async assert, any state): state FILL, cnt 0, buf all 0, pend_last 0, out_valid 0, out_len 0, out_data 0, err 0; in_ready 1 after reset.
- Reset mid-PRESENT or mid-beat: window discarded, no output handshake completes.
- Latency: out_valid rises the cycle after the accepting beat that triggers PRESENT; out_data/out_len are registered.
- out_valid, out_data, out_len held stable while out_valid && !out_ready.
- in_ready drops the cycle after transition to PRESENT; no beat accepted in the same cycle as an output handshake.
- Throughput, discard mode, full beats: 8 accepts + 1 present cycle per window minimum.
- err: exactly one cycle, cycle after the offending handshake.

## Test plan
- Fill: 8 beats of 4 bytes 0x00..0x1F -> out_valid after 8th beat, out_len 32, out_data[255:0] = bytes 0x00..0x1F, bits [271:256] = 0.
- Partial + last: beats (4 bytes 0xA0..A3), (2 bytes 0xB0,B1, in_last) -> out_len 6, bytes A0 A1 A2 A3 B0 B1, rest 0; dec_used 6 -> FILL, cnt 0, err 0.
- Remnant mode (DISCARD_REMNANT=0): 32-byte window, dec_used 10 -> next window bytes 0x0A..0x1F at index 0..21, cnt 22, FILL, in_ready 1.
- Last drain (DISCARD_REMNANT=0): 12 bytes with in_last, dec_used 4 then 4 then 4 -> three windows of len 12, 8, 4 without new input; then FILL.
- Illegal consume: out_len 6, dec_used 9 (and separately 0) -> err pulse 1 cycle, window fully dropped, cnt 0.
- Back-pressure and reset: hold out_ready 0 for 5 cycles -> outputs stable; assert rst_n low mid-PRESENT -> out_valid 0 immediately, out_len 0, in_ready 1 after release.
